// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the riscy32 data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Byte-lane pattern for an access anchored at lane 0.
    function automatic logic [3:0] size_lanes(input mem_size_t size);
        logic [3:0] lanes;
        case (size)
            MEM_BYTE: lanes = 4'b0001;
            MEM_HALF: lanes = 4'b0011;
            default:  lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane steering: byte enables, store data
//               alignment, load extraction/extension and misalignment flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic [1:0]      offset_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rword_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misalign_o
);

    mem_size_t       w_size;
    logic [1:0]      w_lane;
    logic [XLEN-1:0] w_shifted;

    always_comb begin
        w_size     = mem_size_t'(size_i);
        misalign_o = 1'b0;
        w_lane     = 2'b00;
        case (w_size)
            MEM_BYTE: begin
                w_lane = offset_i;
            end
            MEM_HALF: begin
                misalign_o = offset_i[0];
                w_lane     = {offset_i[1], 1'b0};
            end
            MEM_WORD: begin
                misalign_o = (offset_i != 2'b00);
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase

        // Offset bits below the access size are masked, so a misaligned
        // access still lands on the naturally aligned lanes.
        be_o      = size_lanes(w_size) << w_lane;
        wdata_o   = wdata_i << {w_lane, 3'b000};
        w_shifted = rword_i >> {w_lane, 3'b000};

        case (w_size)
            MEM_BYTE: rdata_o = unsigned_i ? {24'b0, w_shifted[7:0]}
                                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_HALF: rdata_o = unsigned_i ? {16'b0, w_shifted[15:0]}
                                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:  rdata_o = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// Module      : data_memory
// Description : RV32 data memory with valid/ready request handshake,
//               configurable wait states and byte/half/word lane access.
//               Optional MEM_ERR_EN reports misaligned/reserved accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_error
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    mem_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [IDX_W+1:0] addr_q;
    logic [1:0]       size_q;
    logic             write_q;
    logic             unsigned_q;
    logic [XLEN-1:0]  wdata_q;

    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic             error_q;

    logic [XLEN-1:0]  mem_q [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic [IDX_W+1:0] op_addr;
    logic [IDX_W-1:0] op_idx;
    logic [1:0]       op_size;
    logic             op_write;
    logic             op_unsigned;
    logic [XLEN-1:0]  op_wdata;
    logic             op_err;
    logic             mem_we;

    logic [3:0]       lane_be;
    logic [XLEN-1:0]  lane_wdata;
    logic [XLEN-1:0]  lane_rdata;
    logic             lane_misalign;

    logic             addr_hi_unused;
    assign addr_hi_unused = ^req_addr[XLEN-1:IDX_W+2];

    assign req_ready = (state_q != WAIT);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every transition into RESP (including RESP->RESP) commits one access.
    assign enter_resp = (state_d == RESP);

    // Without wait states the access commits on its own acceptance edge,
    // so it must come straight from the request inputs.
    always_comb begin
        if (WAIT_STATES == 0) begin
            op_addr     = req_addr[IDX_W+1:0];
            op_size     = req_size;
            op_write    = req_write;
            op_unsigned = req_unsigned;
            op_wdata    = req_wdata;
        end else begin
            op_addr     = addr_q;
            op_size     = size_q;
            op_write    = write_q;
            op_unsigned = unsigned_q;
            op_wdata    = wdata_q;
        end
    end

    assign op_idx = op_addr[IDX_W+1:2];

    mem_lane_align u_lane_align (
        .size_i     (op_size),
        .offset_i   (op_addr[1:0]),
        .unsigned_i (op_unsigned),
        .wdata_i    (op_wdata),
        .rword_i    (mem_q[op_idx]),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata),
        .misalign_o (lane_misalign)
    );

`ifdef MEM_ERR_EN
    assign op_err = lane_misalign;
`else
    logic misalign_unused;
    assign misalign_unused = lane_misalign;
    assign op_err          = 1'b0;
`endif

    assign mem_we  = !reset && enter_resp && op_write && !op_err;
    assign rdata_d = (op_write || op_err) ? '0 : lane_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q     <= req_addr[IDX_W+1:0];
                size_q     <= req_size;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                error_q <= op_err;
            end
        end
    end

    // Storage is deliberately outside the reset domain: reset never clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) begin
                    mem_q[op_idx][i*8 +: 8] <= lane_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
// Module      : tb_data_memory
// Description : Self-checking bench for data_memory: two instances
//               (0 and 3 wait states) checked against a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        vld [2];
    logic        wr  [2];
    logic        uns [2];
    logic [1:0]  sz  [2];
    logic [31:0] addr[2];
    logic [31:0] wd  [2];
    logic        rdy [2];
    logic        rv  [2];
    logic        rerr[2];
    logic [31:0] rd  [2];

    data_memory #(.DEPTH_WORDS(4096), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_write(wr[0]), .req_size(sz[0]), .req_unsigned(uns[0]),
        .req_addr(addr[0]), .req_wdata(wd[0]), .rsp_valid(rv[0]),
        .rsp_rdata(rd[0]), .rsp_error(rerr[0])
    );

    data_memory #(.DEPTH_WORDS(4096), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_write(wr[1]), .req_size(sz[1]), .req_unsigned(uns[1]),
        .req_addr(addr[1]), .req_wdata(wd[1]), .rsp_valid(rv[1]),
        .rsp_rdata(rd[1]), .rsp_error(rerr[1])
    );

    typedef struct {
        bit        wr;
        bit [1:0]  sz;
        bit        uns;
        bit [31:0] a;
        bit [31:0] wd;
        int        due;
    } op_t;

    bit [7:0] mb [2][16384];
    op_t      pend[2][64];
    int       head[2];
    int       tail[2];
    int       next_ok[2];
    int       acc_cnt[2];
    int       ecnt;
    int       n_chk;
    int       n_err;

    function automatic int ws(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Byte-addressed reference: an access touches n consecutive bytes at the
    // size-aligned base within a 16 KiB wrapping space.
    function automatic void model_exec(input int d, input op_t o,
                                       output bit [31:0] r, output bit e);
        int        n;
        int        base;
        bit [13:0] a;
        a = o.a[13:0];
        r = 32'h0;
        e = 1'b0;
`ifdef MEM_ERR_EN
        if ((o.sz == 2'd1 && a[0]) || (o.sz == 2'd2 && a[1:0] != 2'b00) || o.sz == 2'd3) begin
            e = 1'b1;
            return;
        end
`endif
        n    = (o.sz == 2'd0) ? 1 : (o.sz == 2'd1) ? 2 : 4;
        base = int'(a) & ~(n - 1);
        if (o.wr) begin
            for (int i = 0; i < n; i++) mb[d][base + i] = o.wd[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) r[8*i +: 8] = mb[d][base + i];
            if (n < 4 && !o.uns && r[8*n - 1]) begin
                for (int i = 8 * n; i < 32; i++) r[i] = 1'b1;
            end
        end
    endfunction

    // Model tracking on the rising edge, DUT comparison on the falling edge.
    always begin
        op_t       o;
        bit [31:0] mr;
        bit        me;
        int        k;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                head[d]    = tail[d];
                next_ok[d] = ecnt + 1;
            end else if (vld[d] && ecnt >= next_ok[d]) begin
                o.wr  = wr[d];
                o.sz  = sz[d];
                o.uns = uns[d];
                o.a   = addr[d];
                o.wd  = wd[d];
                o.due = ecnt + ws(d);
                pend[d][tail[d] % 64] = o;
                tail[d]++;
                next_ok[d] = ecnt + ws(d) + 1;
                acc_cnt[d]++;
            end
        end
        ecnt++;
        @(negedge clk);
        k = ecnt - 1;
        for (int d = 0; d < 2; d++) begin
            bit exp_v;
            chk($sformatf("req_ready[%0d]@%0d", d, k), {31'b0, rdy[d]},
                {31'b0, (k + 1 >= next_ok[d])});
            exp_v = (head[d] < tail[d]) && (pend[d][head[d] % 64].due == k);
            chk($sformatf("rsp_valid[%0d]@%0d", d, k), {31'b0, rv[d]}, {31'b0, exp_v});
            if (exp_v) begin
                model_exec(d, pend[d][head[d] % 64], mr, me);
                head[d]++;
                chk($sformatf("rsp_rdata[%0d]@%0d", d, k), rd[d], mr);
                chk($sformatf("rsp_error[%0d]@%0d", d, k), {31'b0, rerr[d]}, {31'b0, me});
            end
        end
    end

    task automatic issue(input int d, input bit w, input bit [1:0] s, input bit u,
                         input bit [31:0] a, input bit [31:0] x);
        int c0;
        c0      = acc_cnt[d];
        wr[d]   = w;
        sz[d]   = s;
        uns[d]  = u;
        addr[d] = a;
        wd[d]   = x;
        vld[d]  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt[d] != c0) return;
        end
        n_chk++;
        n_err++;
        $display("FAIL accept[%0d]: actual no acceptance required acceptance within 30 cycles", d);
        vld[d] = 1'b0;
    endtask

    task automatic xact(input int d, input bit w, input bit [1:0] s, input bit u,
                        input bit [31:0] a, input bit [31:0] x,
                        output logic [31:0] r, output logic e);
        issue(d, w, s, u, a, x);
        vld[d] = 1'b0;
        r = 'x;
        e = 1'bx;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rv[d]) begin
                r = rd[d];
                e = rerr[d];
                return;
            end
        end
        n_chk++;
        n_err++;
        $display("FAIL response[%0d]: actual none required rsp_valid within 25 cycles", d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        logic [3:0]  exp_seq;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; vld[d] = 1'b0; wr[d] = 1'b0; uns[d] = 1'b0;
            sz[d] = 2'b00; addr[d] = 32'h0; wd[d] = 32'h0;
            head[d] = 0; tail[d] = 0; next_ok[d] = 0; acc_cnt[d] = 0;
        end
        ecnt = 0; n_chk = 0; n_err = 0;
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset rsp_valid", {31'b0, rv[d]}, 32'h0);
            chk("reset rsp_rdata", rd[d], 32'h0);
            chk("reset rsp_error", {31'b0, rerr[d]}, 32'h0);
            chk("reset req_ready", {31'b0, rdy[d]}, 32'h1);
        end

        // Address wrap-around
        xact(0, 1, 2'd2, 0, 32'h8542_3918, 32'hDEAD_BEEF, r, e);
        chk("sw rdata zero", r, 32'h0);
        xact(0, 0, 2'd2, 0, 32'h0000_3918, 32'h0, r, e);
        chk("wrap lw", r, 32'hDEAD_BEEF);

        // Byte lanes
        xact(0, 1, 2'd0, 0, 32'h101, 32'h0000_00A5, r, e);
        xact(0, 0, 2'd0, 0, 32'h101, 32'h0, r, e);
        chk("lb 0x101", r, 32'hFFFF_FFA5);
        xact(0, 0, 2'd0, 1, 32'h101, 32'h0, r, e);
        chk("lbu 0x101", r, 32'h0000_00A5);
        xact(0, 0, 2'd2, 0, 32'h100, 32'h0, r, e);
        chk("lw 0x100", r, 32'h0000_A500);

        // Half lanes
        xact(0, 1, 2'd1, 0, 32'h202, 32'h0000_8001, r, e);
        xact(0, 0, 2'd1, 0, 32'h202, 32'h0, r, e);
        chk("lh 0x202", r, 32'hFFFF_8001);
        xact(0, 0, 2'd1, 1, 32'h202, 32'h0, r, e);
        chk("lhu 0x202", r, 32'h0000_8001);
        xact(0, 0, 2'd2, 0, 32'h200, 32'h0, r, e);
        chk("lw 0x200", r, 32'h8001_0000);

        // Wait states: ready low for three cycles, single response pulse
        issue(1, 0, 2'd2, 0, 32'h80, 32'h0);
        vld[1] = 1'b0;
        exp_seq = 4'b1000;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("ws3 ready c%0d", j + 1), {31'b0, rdy[1]}, {31'b0, exp_seq[j]});
            chk($sformatf("ws3 valid c%0d", j + 1), {31'b0, rv[1]}, {31'b0, exp_seq[j]});
        end

        // Back-to-back stream with req_valid held
        for (int i = 0; i < 8; i++)
            issue(0, 1, 2'd2, 0, 32'h1000 + 32'(4 * i), (32'h0101_0101 * 32'(i)) ^ 32'hC0DE_0000);
        for (int i = 0; i < 8; i++)
            issue(0, 0, 2'd2, 0, 32'h1000 + 32'(4 * i), 32'h0);
        vld[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        xact(0, 0, 2'd2, 0, 32'h101C, 32'h0, r, e);
        chk("stream lw 0x101c", r, 32'hC7D9_0707);
        xact(0, 0, 2'd2, 0, 32'h3FFC, 32'h0, r, e);
        chk("unwritten 0x3ffc", r, 32'h0);

        // Reset during WAIT drops the store
        issue(1, 1, 2'd2, 0, 32'h40, 32'h1234_5678);
        vld[1] = 1'b0;
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("no rsp after reset", {31'b0, rv[1]}, 32'h0);
        end
        xact(1, 0, 2'd2, 0, 32'h40, 32'h0, r, e);
        chk("lw 0x40 after dropped sw", r, 32'h0);

        // Misaligned and reserved accesses
        xact(0, 1, 2'd2, 0, 32'h40, 32'h1122_3344, r, e);
`ifdef MEM_ERR_EN
        xact(0, 0, 2'd2, 0, 32'h42, 32'h0, r, e);
        chk("lw 0x42 rdata", r, 32'h0);
        chk("lw 0x42 error", {31'b0, e}, 32'h1);
        xact(0, 1, 2'd1, 0, 32'h43, 32'h0000_BEEF, r, e);
        chk("sh 0x43 error", {31'b0, e}, 32'h1);
        xact(0, 0, 2'd2, 0, 32'h40, 32'h0, r, e);
        chk("lw 0x40 unchanged", r, 32'h1122_3344);
        chk("lw 0x40 error", {31'b0, e}, 32'h0);
        xact(0, 0, 2'd3, 0, 32'h40, 32'h0, r, e);
        chk("rsvd size error", {31'b0, e}, 32'h1);
`else
        xact(0, 0, 2'd2, 0, 32'h42, 32'h0, r, e);
        chk("lw 0x42 masked", r, 32'h1122_3344);
        chk("lw 0x42 error", {31'b0, e}, 32'h0);
        xact(0, 0, 2'd3, 0, 32'h40, 32'h0, r, e);
        chk("rsvd size as word", r, 32'h1122_3344);
        xact(0, 1, 2'd1, 0, 32'h43, 32'h0000_BEEF, r, e);
        xact(0, 0, 2'd2, 0, 32'h40, 32'h0, r, e);
        chk("sh 0x43 masked", r, 32'hBEEF_3344);
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
